// File: rtl/z80_bus_responder.sv
// ---------------------------------------------------------------------------
// z80_bus_responder
//   Target-side model of the Z80 bus. Watches the CPU strobes, serves memory
//   reads/writes from an internal RAM, forwards I/O cycles to a simple port
//   interface, stretches cycles with WAIT_L and owns the maskable interrupt
//   line, returning INT_VEC on interrupt acknowledge.
//
// Ports
//   clk, rst                 clock (shared with CPU), async active-high reset
//   addr[15:0], data_in[7:0] CPU address bus and write data
//   data_out[7:0], data_oe   read data to CPU and its bus-drive enable
//   M1_L..RFSH_L             CPU strobes, active-low
//   WAIT_L                   0 = stretch current cycle
//   INT_L                    0 = maskable interrupt pending
//   irq_req                  1-cycle pulse: raise interrupt
//   io_port, io_wdata        port number / write data of current I/O cycle
//   io_wr, io_rd             1-cycle I/O write commit / read strobe
//   io_rdata                 I/O read data, sampled while io_rd is high
// ---------------------------------------------------------------------------
module z80_bus_responder #(
    parameter int         MEM_AW   = 10,
    parameter int         MEM_WAIT = 0,
    parameter int         IO_WAIT  = 1,
    parameter logic [7:0] INT_VEC  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic        M1_L,
    input  logic        MREQ_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        RFSH_L,
    output logic        WAIT_L,
    output logic        INT_L,
    input  logic        irq_req,
    output logic [7:0]  io_port,
    output logic [7:0]  io_wdata,
    output logic        io_wr,
    output logic        io_rd,
    input  logic [7:0]  io_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
    typedef enum logic [1:0] {K_MEM, K_IO, K_INTA} kind_t;

    localparam int         DEPTH = 1 << MEM_AW;
    localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
    localparam logic [3:0] IO_N  = 4'(IO_WAIT);

    logic [7:0]        ram [DEPTH];
    state_t            state;
    kind_t             kind;
    logic              is_read;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        wdata;
    logic [3:0]        cnt;
    logic              pending;

    // Address bits above the RAM window alias; they are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^addr;

    // Request decode, evaluated every cycle but only acted on in IDLE.
    logic       req_valid;
    logic       req_read;
    kind_t      req_kind;
    logic [3:0] req_n;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the if/else chain can infer a latch.
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_kind  = K_MEM;
        if (!IORQ_L && !M1_L) begin
            req_valid = 1'b1;
            req_kind  = K_INTA;
            req_read  = 1'b1;
        end else if (!IORQ_L && (!RD_L || !WR_L)) begin
            req_valid = 1'b1;
            req_kind  = K_IO;
            req_read  = !RD_L;            // RD and WR both low resolves to read
        end else if (!MREQ_L && RFSH_L && (!RD_L || !WR_L)) begin
            req_valid = 1'b1;
            req_kind  = K_MEM;
            req_read  = !RD_L;
        end
        req_n = (req_kind == K_MEM) ? MEM_N : IO_N;
    end

    // A new irq_req in the same cycle as the acknowledge wins over the clear.
    logic inta_done;
    logic pending_next;
    assign inta_done    = (state == S_ACCESS) && (kind == K_INTA);
    assign pending_next = irq_req | (pending & ~inta_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            kind     <= K_MEM;
            is_read  <= 1'b0;
            mem_addr <= '0;
            wdata    <= 8'h00;
            cnt      <= 4'd0;
            pending  <= 1'b0;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
            WAIT_L   <= 1'b1;
            INT_L    <= 1'b1;
            io_port  <= 8'h00;
            io_wdata <= 8'h00;
            io_wr    <= 1'b0;
            io_rd    <= 1'b0;
        end else begin
            pending <= pending_next;
            INT_L   <= ~pending_next;

            case (state)
                S_IDLE: begin
                    data_oe <= 1'b0;
                    if (req_valid) begin
                        kind     <= req_kind;
                        is_read  <= req_read;
                        mem_addr <= addr[MEM_AW-1:0];
                        wdata    <= data_in;
                        if (req_kind == K_IO) begin
                            io_port <= addr[7:0];
                            if (!req_read) io_wdata <= data_in;
                        end
                        if (req_n == 4'd0) begin
                            state <= S_ACCESS;
                            // io strobes are high for exactly the ACCESS cycle
                            io_rd <= (req_kind == K_IO) && req_read;
                            io_wr <= (req_kind == K_IO) && !req_read;
                        end else begin
                            state  <= S_WAIT;
                            cnt    <= req_n;
                            WAIT_L <= 1'b0;
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state  <= S_ACCESS;
                        cnt    <= 4'd0;
                        WAIT_L <= 1'b1;
                        io_rd  <= (kind == K_IO) && is_read;
                        io_wr  <= (kind == K_IO) && !is_read;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_ACCESS: begin
                    io_rd <= 1'b0;
                    io_wr <= 1'b0;
                    state <= S_HOLD;
                    case (kind)
                        K_MEM:   if (is_read) data_out <= ram[mem_addr];
                        K_IO:    if (is_read) data_out <= io_rdata;
                        K_INTA:  data_out <= INT_VEC;
                        default: ;
                    endcase
                end

                S_HOLD: begin
                    // Stay until the CPU ends the cycle so held strobes
                    // cannot start a second access.
                    if (MREQ_L && IORQ_L) begin
                        data_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        data_oe <= is_read;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents must survive rst and a reset
    // branch would also prevent mapping onto block memory.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && kind == K_MEM && !is_read)
            ram[mem_addr] <= wdata;
    end

endmodule
